// File: rtl/dram_sched_pkg.sv
// Shared definitions for the DRAM command scheduler: command codes, FSM states, default geometry.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dram_sched_pkg;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_HS_HI,
        ST_HS_LO,
        ST_REF_SCAN
    } state_t;

    // Default geometry; the widths derived from these are the ones the DRAM model expects.
    localparam int DEF_NUM_OF_BANKS     = 8;
    localparam int DEF_NUM_OF_ROWS      = 128;
    localparam int DEF_NUM_OF_COLS      = 8;
    localparam int DEF_REFRESH_INTERVAL = 64;
    localparam int DEF_BANK_W           = $clog2(DEF_NUM_OF_BANKS);
    localparam int DEF_ROW_W            = $clog2(DEF_NUM_OF_ROWS);
    localparam int DEF_COL_W            = $clog2(DEF_NUM_OF_COLS);

endpackage

// File: rtl/dram_bank_table.sv
// Per-bank open-row table: open bits + row registers, one-bank lookup, lowest-open-bank search.
// Latency: lookups are combinational; ACT/PRE events take effect on the next rising edge.
// Backpressure: none, an event is applied in the cycle it is presented.
// Ports: act_evt/pre_evt + evt_bank/evt_row update the table; look_bank/look_row give
//        look_open/look_hit; any_open/first_open drive the refresh precharge scan.
module dram_bank_table
    import dram_sched_pkg::*;
#(
    parameter  int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter  int ROW_W        = DEF_ROW_W,
    localparam int BANK_W       = $clog2(NUM_OF_BANKS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              act_evt,
    input  logic              pre_evt,
    input  logic [BANK_W-1:0] evt_bank,
    input  logic [ROW_W-1:0]  evt_row,
    input  logic [BANK_W-1:0] look_bank,
    input  logic [ROW_W-1:0]  look_row,
    output logic              look_open,
    output logic              look_hit,
    output logic              any_open,
    output logic [BANK_W-1:0] first_open
);

    logic [NUM_OF_BANKS-1:0] open_q;
    logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            open_q <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                row_q[i] <= '0;
            end
        end else if (act_evt) begin
            open_q[evt_bank] <= 1'b1;
            row_q[evt_bank]  <= evt_row;
        end else if (pre_evt) begin
            open_q[evt_bank] <= 1'b0;
        end
    end

    assign look_open = open_q[look_bank];
    assign look_hit  = open_q[look_bank] && (row_q[look_bank] == look_row);
    assign any_open  = |open_q;

    // Scan from the top down so the lowest open index is the last (winning) write.
    always_comb begin
        first_open = '0;
        for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
            if (open_q[i]) begin
                first_open = BANK_W'(i);
            end
        end
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Turns one L2 request at a time into ACT/PRE/RD/WR commands (open-page), plus periodic refresh precharge.
// Latency: per command 1 PLAN + >=1 HS_HI + >=1 HS_LO cycle; req_done registered after the RD/WR handshake.
// Backpressure: req_ready only in IDLE with no refresh pending; cmd_req holds until cmd_ack (four-phase).
// Ports: req_* request in; cmd_req/cmd_ack handshake with cmd/cmd_bank/cmd_row/cmd_col;
//        req_done and refresh_done are single-cycle completion pulses.
module dram_cmd_scheduler
    import dram_sched_pkg::*;
#(
    parameter  int NUM_OF_BANKS     = DEF_NUM_OF_BANKS,
    parameter  int NUM_OF_ROWS      = DEF_NUM_OF_ROWS,
    parameter  int NUM_OF_COLS      = DEF_NUM_OF_COLS,
    parameter  int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    localparam int BANK_W           = $clog2(NUM_OF_BANKS),
    localparam int ROW_W            = $clog2(NUM_OF_ROWS),
    localparam int COL_W            = $clog2(NUM_OF_COLS),
    localparam int CNT_W            = $clog2(REFRESH_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic              cmd_req,
    input  logic              cmd_ack,
    output logic [1:0]        cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              req_done,
    output logic              refresh_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_INTERVAL - 1);

    state_t            state, state_nxt;
    logic              lat_rw;
    logic [BANK_W-1:0] lat_bank;
    logic [ROW_W-1:0]  lat_row;
    logic [COL_W-1:0]  lat_col;
    logic              in_ref;
    logic              ref_pending;
    logic [CNT_W-1:0]  ref_cnt;

    logic              look_open, look_hit, any_open;
    logic [BANK_W-1:0] first_open;
    logic [1:0]        plan_cmd;
    logic              cmd_is_rw, hs_ack, hs_lo_exit;

    assign req_ready  = (state == ST_IDLE) && !ref_pending;
    assign cmd_req    = (state == ST_HS_HI);
    assign cmd_is_rw  = (cmd == CMD_RD) || (cmd == CMD_WR);
    assign hs_ack     = (state == ST_HS_HI) && cmd_ack;
    assign hs_lo_exit = (state == ST_HS_LO) && !cmd_ack;

    dram_bank_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .ROW_W        (ROW_W)
    ) u_bank_table (
        .clk        (clk),
        .rst_b      (rst_b),
        .act_evt    (hs_ack && (cmd == CMD_ACT)),
        .pre_evt    (hs_ack && (cmd == CMD_PRE)),
        .evt_bank   (cmd_bank),
        .evt_row    (cmd_row),
        .look_bank  (lat_bank),
        .look_row   (lat_row),
        .look_open  (look_open),
        .look_hit   (look_hit),
        .any_open   (any_open),
        .first_open (first_open)
    );

    // Open-page decision for the latched request; re-run after every PRE/ACT.
    always_comb begin
        plan_cmd = CMD_ACT;
        if (look_hit) begin
            plan_cmd = lat_rw ? CMD_WR : CMD_RD;
        end else if (look_open) begin
            plan_cmd = CMD_PRE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PLAN and REF_SCAN also wait for a low ack so cmd_req never rises onto a stale ack.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ref_pending) begin
                    state_nxt = ST_REF_SCAN;
                end else if (req_valid) begin
                    state_nxt = ST_PLAN;
                end
            end
            ST_PLAN: begin
                if (!cmd_ack) begin
                    state_nxt = ST_HS_HI;
                end
            end
            ST_HS_HI: begin
                if (cmd_ack) begin
                    state_nxt = ST_HS_LO;
                end
            end
            ST_HS_LO: begin
                if (!cmd_ack) begin
                    if (in_ref) begin
                        state_nxt = ST_REF_SCAN;
                    end else if (cmd_is_rw) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_PLAN;
                    end
                end
            end
            ST_REF_SCAN: begin
                if (!any_open) begin
                    state_nxt = ST_IDLE;
                end else if (!cmd_ack) begin
                    state_nxt = ST_HS_HI;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            lat_rw       <= 1'b0;
            lat_bank     <= '0;
            lat_row      <= '0;
            lat_col      <= '0;
            cmd          <= CMD_ACT;
            cmd_bank     <= '0;
            cmd_row      <= '0;
            cmd_col      <= '0;
            req_done     <= 1'b0;
            refresh_done <= 1'b0;
            in_ref       <= 1'b0;
            ref_pending  <= 1'b0;
            ref_cnt      <= '0;
        end else begin
            req_done     <= 1'b0;
            refresh_done <= 1'b0;

            ref_cnt <= (ref_cnt == CNT_MAX) ? '0 : ref_cnt + CNT_W'(1);
            // Expiry while pending just re-sets the flag: at most one refresh is ever queued.
            if (ref_cnt == CNT_MAX) begin
                ref_pending <= 1'b1;
            end else if ((state == ST_REF_SCAN) && !any_open) begin
                ref_pending <= 1'b0;
            end

            if (req_ready && req_valid) begin
                lat_rw   <= req_rw;
                lat_bank <= req_bank;
                lat_row  <= req_row;
                lat_col  <= req_col;
            end

            if ((state == ST_IDLE) && ref_pending) begin
                in_ref <= 1'b1;
            end

            if (state == ST_PLAN) begin
                cmd      <= plan_cmd;
                cmd_bank <= lat_bank;
                cmd_row  <= lat_row;
                cmd_col  <= (plan_cmd == CMD_ACT) ? '0 : lat_col;
            end

            if (state == ST_REF_SCAN) begin
                if (any_open) begin
                    cmd      <= CMD_PRE;
                    cmd_bank <= first_open;
                    cmd_row  <= '0;
                    cmd_col  <= '0;
                end else begin
                    refresh_done <= 1'b1;
                    in_ref       <= 1'b0;
                end
            end

            if (hs_lo_exit && !in_ref && cmd_is_rw) begin
                req_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench for dram_cmd_scheduler: directed requests push expected command/pulse streams.
// Latency: ack responder answers cmd_req one cycle late and drops ack one cycle after cmd_req falls.
// Backpressure: requests are held on req_valid until req_ready is seen.
module tb_dram_cmd_scheduler;

    localparam int BW = 3;
    localparam int RW = 7;
    localparam int CW = 3;

    localparam logic [1:0] K_CMD  = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_REF  = 2'd2;

    localparam logic [1:0] C_ACT = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_WR  = 2'b10;
    localparam logic [1:0] C_PRE = 2'b11;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [BW-1:0] req_bank;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic          cmd_req;
    logic          cmd_ack;
    logic [1:0]    cmd;
    logic [BW-1:0] cmd_bank;
    logic [RW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic          req_done;
    logic          refresh_done;

    typedef struct packed {
        logic [1:0]    kind;
        logic [1:0]    c;
        logic [BW-1:0] b;
        logic [RW-1:0] r;
        logic [CW-1:0] col;
    } ev_t;

    ev_t sb[$];
    int  n_cmp   = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  rel_cyc = 0;

    dram_cmd_scheduler dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_bank     (req_bank),
        .req_row      (req_row),
        .req_col      (req_col),
        .cmd_req      (cmd_req),
        .cmd_ack      (cmd_ack),
        .cmd          (cmd),
        .cmd_bank     (cmd_bank),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .req_done     (req_done),
        .refresh_done (refresh_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [1:0] cc, input int bb, input int rr, input int cl);
        ev_t e;
        e.kind = k;
        e.c    = cc;
        e.b    = BW'(bb);
        e.r    = RW'(rr);
        e.col  = CW'(cl);
        return e;
    endfunction

    task automatic exp_cmd(input logic [1:0] cc, input int bb, input int rr, input int cl);
        sb.push_back(mk(K_CMD, cc, bb, rr, cl));
    endtask

    task automatic exp_done();
        sb.push_back(mk(K_DONE, 2'b00, 0, 0, 0));
    endtask

    task automatic exp_ref();
        sb.push_back(mk(K_REF, 2'b00, 0, 0, 0));
    endtask

    task automatic pop_cmp(input string name, input ev_t a);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got unexpected event %0h, expected nothing", name, a);
        end else begin
            e = sb.pop_front();
            check(name, 32'(a), 32'(e));
        end
    endtask

    // Monitor: every observed command start and pulse is checked against the scoreboard in order.
    logic prev_req = 1'b0;
    ev_t  held;
    always @(negedge clk) begin
        ev_t a;
        if (cmd_req && prev_req) begin
            check("cmd_stable", 32'({cmd, cmd_bank, cmd_row, cmd_col}),
                  32'({held.c, held.b, held.r, held.col}));
        end
        if (cmd_req && !prev_req) begin
            check("ack_low_at_cmd_rise", 32'(cmd_ack), 32'(0));
            a    = mk(K_CMD, cmd, int'(cmd_bank), int'(cmd_row), int'(cmd_col));
            held = a;
            pop_cmp("cmd", a);
        end
        if (req_done) pop_cmp("req_done", mk(K_DONE, 2'b00, 0, 0, 0));
        if (refresh_done) pop_cmp("refresh_done", mk(K_REF, 2'b00, 0, 0, 0));
        prev_req = cmd_req;
    end

    // Four-phase responder: ack follows cmd_req with one cycle of delay.
    logic req_seen;
    initial begin
        cmd_ack  = 1'b0;
        req_seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_b) begin
                cmd_ack  = 1'b0;
                req_seen = 1'b0;
            end else begin
                cmd_ack  = req_seen;
                req_seen = cmd_req;
            end
        end
    end

    task automatic wait_rel(input int n);
        while (cyc - rel_cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_b   = 1'b0;
        rel_cyc = cyc;
    endtask

    // Call at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic do_req(input logic rw, input int b, input int r, input int c);
        int t = 0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_bank  = BW'(b);
        req_row   = RW'(r);
        req_col   = CW'(c);
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) timeout("req_accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pulse(input bit refr, input int limit);
        int t    = 0;
        bit seen = 1'b0;
        while (!seen && t < limit) begin
            @(negedge clk);
            if (refr ? refresh_done : req_done) seen = 1'b1;
            t++;
        end
        if (!seen) timeout(refr ? "wait_refresh_done" : "wait_req_done");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;

        // Reset values
        do_reset();
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_cmd_req", 32'(cmd_req), 32'(0));
        check("rst_cmd", 32'(cmd), 32'(0));
        check("rst_cmd_addr", 32'({cmd_bank, cmd_row, cmd_col}), 32'(0));
        check("rst_req_done", 32'(req_done), 32'(0));
        check("rst_refresh_done", 32'(refresh_done), 32'(0));

        // Closed-bank write, row hit, row miss
        exp_cmd(C_ACT, 2, 5, 0); exp_cmd(C_WR, 2, 5, 3); exp_done();
        do_req(1'b1, 2, 5, 3); wait_pulse(1'b0, 60);
        exp_cmd(C_RD, 2, 5, 7); exp_done();
        do_req(1'b0, 2, 5, 7); wait_pulse(1'b0, 60);
        exp_cmd(C_PRE, 2, 9, 0); exp_cmd(C_ACT, 2, 9, 0); exp_cmd(C_RD, 2, 9, 0); exp_done();
        do_req(1'b0, 2, 9, 0); wait_pulse(1'b0, 60);

        // First refresh after reset: counter started at 0, bank 2 still open
        exp_cmd(C_PRE, 2, 0, 0); exp_ref();
        wait_rel(63);
        check("ready_before_expiry", 32'(req_ready), 32'(1));
        wait_rel(64);
        check("ready_at_expiry", 32'(req_ready), 32'(0));
        wait_pulse(1'b1, 100);

        // Open banks 1, 4, 6 then refresh them in index order
        exp_cmd(C_ACT, 1, 3, 0); exp_cmd(C_RD, 1, 3, 2); exp_done();
        do_req(1'b0, 1, 3, 2); wait_pulse(1'b0, 60);
        exp_cmd(C_ACT, 4, 10, 0); exp_cmd(C_WR, 4, 10, 5); exp_done();
        do_req(1'b1, 4, 10, 5); wait_pulse(1'b0, 60);
        exp_cmd(C_ACT, 6, 127, 0); exp_cmd(C_RD, 6, 127, 7); exp_done();
        do_req(1'b0, 6, 127, 7); wait_pulse(1'b0, 60);
        exp_cmd(C_PRE, 1, 0, 0); exp_cmd(C_PRE, 4, 0, 0); exp_cmd(C_PRE, 6, 0, 0); exp_ref();
        wait_rel(128);
        check("ready_refresh_start", 32'(req_ready), 32'(0));
        begin
            int  t    = 0;
            bit  seen = 1'b0;
            while (!seen && t < 100) begin
                @(negedge clk);
                if (refresh_done) seen = 1'b1;
                else check("ready_during_refresh", 32'(req_ready), 32'(0));
                t++;
            end
            if (!seen) timeout("refresh_136");
            @(posedge clk);
            #1;
        end
        exp_cmd(C_ACT, 4, 10, 0); exp_cmd(C_RD, 4, 10, 1); exp_done();
        do_req(1'b0, 4, 10, 1); wait_pulse(1'b0, 60);

        // Request presented while refresh is pending: refresh first
        do_reset();
        exp_cmd(C_ACT, 3, 1, 0); exp_cmd(C_WR, 3, 1, 2); exp_done();
        do_req(1'b1, 3, 1, 2); wait_pulse(1'b0, 60);
        exp_cmd(C_PRE, 3, 0, 0); exp_ref();
        exp_cmd(C_ACT, 3, 1, 0); exp_cmd(C_RD, 3, 1, 4); exp_done();
        wait_rel(64);
        check("ready_simul", 32'(req_ready), 32'(0));
        do_req(1'b0, 3, 1, 4); wait_pulse(1'b0, 100);

        // Reset in the middle of an ACT handshake
        exp_cmd(C_ACT, 5, 7, 0);
        do_req(1'b1, 5, 7, 1);
        begin
            int t = 0;
            while (!cmd_req && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!cmd_req) timeout("mid_hs_cmd_req");
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cmd_req", 32'(cmd_req), 32'(0));
        check("midrst_req_ready", 32'(req_ready), 32'(1));
        rst_b   = 1'b0;
        rel_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_req_done", 32'(req_done), 32'(0));
        end
        @(posedge clk);
        #1;
        exp_cmd(C_ACT, 5, 7, 0); exp_cmd(C_WR, 5, 7, 1); exp_done();
        do_req(1'b1, 5, 7, 1); wait_pulse(1'b0, 60);
        exp_cmd(C_PRE, 5, 0, 0); exp_ref();
        wait_rel(63);
        check("midrst_ready_before_expiry", 32'(req_ready), 32'(1));
        wait_rel(64);
        check("midrst_ready_at_expiry", 32'(req_ready), 32'(0));
        wait_pulse(1'b1, 100);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
